// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter with session hold: the owner keeps its grant
// until it drops its request or signals end of session; the last winner gets lowest priority.
module rr_arbiter (
    input  logic       clk,
    input  logic       rst_an,
    input  logic [3:0] req,
    input  logic       session_is_finished,
    output logic [3:0] grant
);

    logic [3:0] r_grant;
    logic [1:0] r_rotate_ptr;

    logic [3:0] w_shift_req;
    logic [3:0] w_shift_grant;
    logic [1:0] w_shift_idx;
    logic [3:0] w_arb_grant;
    logic [1:0] w_win_idx;
    logic       w_arb_valid;
    logic       w_arbitrate;

    // Rotate requests so that the highest-priority requester lands on bit 0.
    always_comb begin
        w_shift_req = '0;
        for (int k = 0; k < 4; k++) begin
            w_shift_req[k] = req[2'(r_rotate_ptr + 2'(k))];
        end
    end

    always_comb begin
        w_shift_grant = '0;
        w_shift_idx   = '0;
        w_arb_valid   = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (w_shift_req[k]) begin
                w_shift_grant = 4'b0001 << k;
                w_shift_idx   = 2'(k);
                w_arb_valid   = 1'b1;
            end
        end
    end

    always_comb begin
        w_arb_grant = '0;
        for (int k = 0; k < 4; k++) begin
            w_arb_grant[2'(r_rotate_ptr + 2'(k))] = w_shift_grant[k];
        end
        w_win_idx = r_rotate_ptr + w_shift_idx;
    end

    // An idle arbiter also has no owner request, so one term covers idle and release.
    assign w_arbitrate = ~|(r_grant & req) | session_is_finished;

    always_ff @(posedge clk or posedge rst_an) begin
        if (rst_an) begin
            r_grant      <= '0;
            r_rotate_ptr <= '0;
        end else if (w_arbitrate) begin
            r_grant <= w_arb_grant;
            if (w_arb_valid) begin
                r_rotate_ptr <= w_win_idx + 2'd1;
            end
        end
    end

    assign grant = r_grant;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a behavioural model predicts grant and pointer
// each cycle; predictions are queued at drive time and compared after the edge.
module tb_rr_arbiter;

    logic       clk;
    logic       rst_an;
    logic [3:0] req;
    logic       session_is_finished;
    logic [3:0] grant;

    int n_vec;
    int n_err;

    logic [3:0] m_grant;
    logic [1:0] m_ptr;
    logic [5:0] exp_q[$];

    rr_arbiter dut (
        .clk                 (clk),
        .rst_an              (rst_an),
        .req                 (req),
        .session_is_finished (session_is_finished),
        .grant               (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] r, input logic s);
        logic       found;
        logic [3:0] g;
        int         idx;
        int         win;
        if (m_grant == 4'b0 || (m_grant & r) == 4'b0 || s) begin
            found = 1'b0;
            g     = 4'b0;
            win   = 0;
            for (int k = 0; k < 4; k++) begin
                idx = (int'(m_ptr) + k) % 4;
                if (!found && r[idx]) begin
                    found = 1'b1;
                    g     = 4'b0001 << idx;
                    win   = idx;
                end
            end
            m_grant = g;
            if (found) m_ptr = 2'((win + 1) % 4);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic s);
        logic [5:0] e;
        @(negedge clk);
        req                 = r;
        session_is_finished = s;
        model_edge(r, s);
        exp_q.push_back({m_grant, m_ptr});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            chk("grant", {4'b0, grant}, {4'b0, e[5:2]});
            chk("ptr", {6'b0, dut.r_rotate_ptr}, {6'b0, e[1:0]});
            chk("onehot", {7'b0, $countones(grant) <= 1}, 8'd1);
        end
    endtask

    initial begin
        n_vec               = 0;
        n_err               = 0;
        req                 = 4'b0;
        session_is_finished = 1'b0;
        rst_an              = 1'b1;
        m_grant             = 4'b0;
        m_ptr               = 2'd0;
        #1;
        chk("reset_grant", {4'b0, grant}, 8'h00);
        chk("reset_ptr", {6'b0, dut.r_rotate_ptr}, 8'h00);
        @(negedge clk);
        rst_an = 1'b0;

        // Single requester, then release.
        step(4'b0100, 1'b0);
        chk("plan1_grant", {4'b0, grant}, 8'h04);
        step(4'b0000, 1'b0);
        chk("plan1_release", {4'b0, grant}, 8'h00);
        chk("plan1_ptr", {6'b0, dut.r_rotate_ptr}, 8'h03);

        // Held request keeps its grant.
        for (int i = 0; i < 5; i++) step(4'b0010, 1'b0);
        chk("plan2_grant", {4'b0, grant}, 8'h02);
        chk("plan2_ptr", {6'b0, dut.r_rotate_ptr}, 8'h02);

        // Owner drops, another takes over with no dead cycle.
        step(4'b0001, 1'b0);
        chk("plan3_grant", {4'b0, grant}, 8'h01);

        // Session pulse with competitors, then hold.
        step(4'b1101, 1'b1);
        chk("plan4_grant", {4'b0, grant}, 8'h04);
        chk("plan4_ptr", {6'b0, dut.r_rotate_ptr}, 8'h03);
        for (int i = 0; i < 3; i++) step(4'b1101, 1'b0);
        chk("plan4_hold", {4'b0, grant}, 8'h04);

        // Session finished held high rotates every cycle.
        step(4'b1101, 1'b1);
        chk("plan5_a", {4'b0, grant}, 8'h08);
        step(4'b1101, 1'b1);
        chk("plan5_b", {4'b0, grant}, 8'h01);
        step(4'b1101, 1'b1);
        chk("plan5_c", {4'b0, grant}, 8'h04);
        step(4'b1101, 1'b1);
        chk("plan5_d", {4'b0, grant}, 8'h08);

        // Lone requester is re-granted across session pulses.
        for (int i = 0; i < 4; i++) step(4'b0001, i[0]);
        chk("plan6_grant", {4'b0, grant}, 8'h01);

        // Mid-session asynchronous reset, checked between clock edges.
        @(negedge clk);
        #2;
        rst_an = 1'b1;
        #1;
        chk("async_rst_grant", {4'b0, grant}, 8'h00);
        chk("async_rst_ptr", {6'b0, dut.r_rotate_ptr}, 8'h00);
        m_grant = 4'b0;
        m_ptr   = 2'd0;
        exp_q.delete();
        @(negedge clk);
        rst_an = 1'b0;

        // First order after reset is 0,1,2,3.
        step(4'b1110, 1'b0);
        chk("post_rst_grant", {4'b0, grant}, 8'h02);

        // Wrap-around: winner 3 moves pointer to 0.
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b1);
        chk("wrap_ptr", {6'b0, dut.r_rotate_ptr}, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
